// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// DMEM_ARB_LOCK_EN enables the port-1 lock state in the arbiter.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } arb_state_e;

  localparam int P0 = 0;
  localparam int P1 = 1;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: on contention the port that did not win last time is picked.
module rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req0 & (~req1 | last);
    gnt[1] = req1 & (~req0 | ~last);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the single-port data memory (pipeline port 0, loader port 1).
// Define DMEM_ARB_LOCK_EN to add the p1_lock input and the LOCK1 ownership state.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              p1_lock,
`endif
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              misalign_err
);

  arb_state_e        state_q;
  logic              last_q;
  logic              lock_hold;
  logic              req0_eff;
  logic              req1_eff;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              misal;

  // Port 0 is only masked while the lock is still asserted; the release cycle arbitrates normally.
`ifdef DMEM_ARB_LOCK_EN
  assign lock_hold = (state_q == LOCK1) && p1_lock;
`else
  assign lock_hold = (state_q == LOCK1);
`endif

  // Gating with rst keeps the combinational grants low while reset is held.
  assign req0_eff = p0_req & ~lock_hold & rst;
  assign req1_eff = p1_req & rst;

  rr_pick2 u_pick (
    .req0 (req0_eff),
    .req1 (req1_eff),
    .last (last_q),
    .gnt  (gnt)
  );

  assign p0_gnt  = gnt[P0];
  assign p1_gnt  = gnt[P1];
  assign any_gnt = gnt[P0] | gnt[P1];

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt[P0]) begin
      sel_we    = p0_we;
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
    end else if (gnt[P1]) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  assign misal     = any_gnt & is_misaligned(sel_addr[1:0]);
  assign mem_we    = sel_we & ~misal;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB;
      last_q       <= 1'b1;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
      p0_rvalid    <= 1'b0;
      p1_rvalid    <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      p0_rvalid    <= 1'b0;
      p1_rvalid    <= 1'b0;
      misalign_err <= misal;

      if (gnt[P0]) begin
        last_q <= 1'b0;
        if (!p0_we) begin
          p0_rdata  <= misal ? '0 : mem_rdata;
          p0_rvalid <= 1'b1;
        end
      end

      if (gnt[P1]) begin
        last_q <= 1'b1;
        if (!p1_we) begin
          p1_rdata  <= misal ? '0 : mem_rdata;
          p1_rvalid <= 1'b1;
        end
      end

`ifdef DMEM_ARB_LOCK_EN
      unique case (state_q)
        ARB:     if (gnt[P1] && p1_lock) state_q <= LOCK1;
        LOCK1:   if (!p1_lock) state_q <= ARB;
        default: state_q <= ARB;
      endcase
`else
      state_q <= ARB;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        misalign_err;

  logic [31:0] mem [16];
  int          n_tests;
  int          n_fail;

  dmem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_req       (p0_req),
    .p0_we        (p0_we),
    .p0_addr      (p0_addr),
    .p0_wdata     (p0_wdata),
    .p1_req       (p1_req),
    .p1_we        (p1_we),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .p1_lock      (p1_lock),
`endif
    .p0_gnt       (p0_gnt),
    .p1_gnt       (p1_gnt),
    .p0_rdata     (p0_rdata),
    .p1_rdata     (p1_rdata),
    .p0_rvalid    (p0_rvalid),
    .p1_rvalid    (p1_rvalid),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[(mem_addr >> 2) % 16];

  always @(posedge clk) begin
    if (mem_we) mem[(mem_addr >> 2) % 16] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic r0, input logic w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic r1, input logic w1,
                        input logic [31:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic to_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst     = 1'b0;
    p1_lock = 1'b0;
    set_in(1'b1, 1'b0, 32'd8, 32'h0, 1'b1, 1'b0, 32'd12, 32'h0);

    // Reset state, with requests present to show grants are held off.
    #2;
    check("rst_p0_gnt", {31'b0, p0_gnt}, 32'd0);
    check("rst_p1_gnt", {31'b0, p1_gnt}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rvalid", {30'b0, p0_rvalid, p1_rvalid}, 32'd0);
    check("rst_rdata", p0_rdata | p1_rdata, 32'd0);
    check("rst_err", {31'b0, misalign_err}, 32'd0);
    set_in(1'b0, 1'b0, 32'd0, 32'h0, 1'b0, 1'b0, 32'd0, 32'h0);
    #6 rst = 1'b1;
    to_edge();

    // Lone p0 write of addr 8.
    set_in(1'b1, 1'b1, 32'd8, 32'hAAAABBBB, 1'b0, 1'b0, 32'd0, 32'h0);
    @(negedge clk);
    check("wr_p0_gnt", {31'b0, p0_gnt}, 32'd1);
    check("wr_p1_gnt", {31'b0, p1_gnt}, 32'd0);
    check("wr_mem_we", {31'b0, mem_we}, 32'd1);
    check("wr_mem_addr", mem_addr, 32'd8);
    check("wr_mem_wdata", mem_wdata, 32'hAAAABBBB);
    to_edge();
    check("wr_no_rvalid", {31'b0, p0_rvalid}, 32'd0);

    // p0 read back of addr 8.
    set_in(1'b1, 1'b0, 32'd8, 32'h0, 1'b0, 1'b0, 32'd0, 32'h0);
    @(negedge clk);
    check("rd_p0_gnt", {31'b0, p0_gnt}, 32'd1);
    check("rd_mem_we", {31'b0, mem_we}, 32'd0);
    to_edge();
    check("rd_p0_rvalid", {31'b0, p0_rvalid}, 32'd1);
    check("rd_p0_rdata", p0_rdata, 32'hAAAABBBB);
    check("rd_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);

    // p1 write of addr 12; last becomes 1 so p0 wins the next contention.
    set_in(1'b0, 1'b0, 32'd0, 32'h0, 1'b1, 1'b1, 32'd12, 32'hCCCCDDDD);
    @(negedge clk);
    check("wr1_p1_gnt", {31'b0, p1_gnt}, 32'd1);
    check("wr1_mem_we", {31'b0, mem_we}, 32'd1);
    check("wr1_mem_addr", mem_addr, 32'd12);
    to_edge();
    check("wr1_rvalid", {30'b0, p0_rvalid, p1_rvalid}, 32'd0);

    // Both read every cycle: grants alternate 0,1,0,1.
    set_in(1'b1, 1'b0, 32'd8, 32'h0, 1'b1, 1'b0, 32'd12, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_gnt", {30'b0, p1_gnt, p0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
      to_edge();
      check("rr_rvalid", {30'b0, p1_rvalid, p0_rvalid}, (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i % 2 == 0) check("rr_p0_rdata", p0_rdata, 32'hAAAABBBB);
      else            check("rr_p1_rdata", p1_rdata, 32'hCCCCDDDD);
    end

    // Idle cycle: mem bus must be zero even with stale addresses on the ports.
    set_in(1'b0, 1'b1, 32'd8, 32'h1111, 1'b0, 1'b1, 32'd12, 32'h2222);
    @(negedge clk);
    check("idle_gnt", {30'b0, p1_gnt, p0_gnt}, 32'd0);
    check("idle_mem_we", {31'b0, mem_we}, 32'd0);
    check("idle_mem_addr", mem_addr, 32'd0);
    check("idle_mem_wdata", mem_wdata, 32'd0);
    to_edge();

    // Misaligned p1 write to addr 13: granted, no write, error next cycle.
    set_in(1'b0, 1'b0, 32'd0, 32'h0, 1'b1, 1'b1, 32'd13, 32'h12345678);
    @(negedge clk);
    check("mis_p1_gnt", {31'b0, p1_gnt}, 32'd1);
    check("mis_mem_we", {31'b0, mem_we}, 32'd0);
    check("mis_mem_addr", mem_addr, 32'd13);
    to_edge();
    check("mis_err", {31'b0, misalign_err}, 32'd1);
    check("mis_rvalid", {31'b0, p1_rvalid}, 32'd0);

    // Read addr 12 back: unchanged, and the error pulse has ended.
    set_in(1'b0, 1'b0, 32'd0, 32'h0, 1'b1, 1'b0, 32'd12, 32'h0);
    to_edge();
    check("mis_err_end", {31'b0, misalign_err}, 32'd0);
    check("mis_mem12", p1_rdata, 32'hCCCCDDDD);

    // Misaligned p0 read: returns zero with rvalid and error.
    set_in(1'b1, 1'b0, 32'd9, 32'h0, 1'b0, 1'b0, 32'd0, 32'h0);
    to_edge();
    check("misrd_rvalid", {31'b0, p0_rvalid}, 32'd1);
    check("misrd_rdata", p0_rdata, 32'd0);
    check("misrd_err", {31'b0, misalign_err}, 32'd1);

`ifdef DMEM_ARB_LOCK_EN
    // last = 0, so p1 wins and takes the lock; p0 starves for 4 cycles.
    set_in(1'b1, 1'b0, 32'd8, 32'h0, 1'b1, 1'b0, 32'd12, 32'h0);
    p1_lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lock_gnt", {30'b0, p1_gnt, p0_gnt}, 32'd2);
      to_edge();
    end
    p1_lock = 1'b0;
    @(negedge clk);
    check("unlock_gnt", {30'b0, p1_gnt, p0_gnt}, 32'd1);
    to_edge();
`endif

    // Reset right after a granted read: rvalid cleared and stays low.
    set_in(1'b1, 1'b0, 32'd8, 32'h0, 1'b0, 1'b0, 32'd0, 32'h0);
    @(negedge clk);
    check("pre_rst_gnt", {31'b0, p0_gnt}, 32'd1);
    to_edge();
    check("pre_rst_rvalid", {31'b0, p0_rvalid}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_rvalid", {31'b0, p0_rvalid}, 32'd0);
    check("mid_rst_rdata", p0_rdata, 32'd0);
    check("mid_rst_gnt", {31'b0, p0_gnt}, 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    to_edge();
    check("mid_rst_rvalid2", {31'b0, p0_rvalid}, 32'd0);

    // After release p0 wins the first contention again.
    set_in(1'b1, 1'b0, 32'd8, 32'h0, 1'b1, 1'b0, 32'd12, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", {30'b0, p1_gnt, p0_gnt}, 32'd1);
    to_edge();
    check("post_rst_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 32'd1);
    check("post_rst_rdata", p0_rdata, 32'hAAAABBBB);

    set_in(1'b0, 1'b0, 32'd0, 32'h0, 1'b0, 1'b0, 32'd0, 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Two-requester arbiter for the single-port data memory: sync write, combinational read.
- Port 0 is the pipeline MEM stage; port 1 is the loader/debug port, which preloads and inspects data memory during bring-up.
- Grants one access per cycle using round-robin priority.
- Registers read data with a one-cycle valid pulse, flags misaligned word accesses, and can optionally lock the memory to port 1 for bursts.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- p0_req / p1_req  in  1  access request, held until granted
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  ADDR_W  byte address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_gnt / p1_gnt  out  1  combinational grant, same cycle as request
- p0_rdata / p1_rdata  out  DATA_W  registered read data
- p0_rvalid / p1_rvalid  out  1  one-cycle pulse, cycle after a granted read
- p1_lock  in  1  hold ownership for port 1 (only with DMEM_ARB_LOCK_EN)
- mem_we  out  1  to memory write enable
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory write data
- mem_rdata  in  DATA_W  from memory, combinational read
- misalign_err  out  1  one-cycle pulse, cycle after a granted misaligned access

## Operation
- At most one grant per cycle; the granted port's we/addr/wdata drive the mem_* outputs.
- With no grant: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Round-robin: a `last` register records the most recently granted port. On contention, the port other than `last` wins. A lone requester always wins.
- Reset value of `last` is 1, so port 0 wins the first contention.
- Granted read: mem_rdata is captured into that port's rdata register at the grant edge, and rvalid pulses the next cycle. The other port's rdata holds its previous value.
- Granted write: the memory writes at the grant edge. The grant itself is the write acknowledge, and rvalid stays 0.
- Misaligned access (addr[1:0] != 0): still granted and consumes the slot.
  - mem_we is forced 0, so no write occurs.
  - A read returns rdata = 0 with rvalid pulsed.
  - misalign_err pulses the next cycle.
- FSM states:
  - ARB: normal round-robin.
  - LOCK1: only port 1 may be granted (macro only).
  - ARB → LOCK1 when port 1 is granted with p1_lock = 1.
  - LOCK1 → ARB on the first cycle p1_lock = 0. That cycle arbitrates normally.
- Reset mid-operation: all outputs and registers clear immediately. Any in-flight rvalid or err is lost. The FSM returns to ARB.

## Timing
- Reset values: p*_gnt = 0, p*_rdata = 0, p*_rvalid = 0, misalign_err = 0, mem_* = 0, state = ARB, last = 1.
- Grant latency: 0 cycles (combinational from req and state).
- Read latency: rdata/rvalid valid 1 cycle after grant.
- Write: takes effect at the grant edge.
- Back-to-back: a held request on both ports alternates grants every cycle (0,1,0,1,…).
- Simultaneous read and write contention: resolved by round-robin only; the access type does not matter.

## Configuration
- `DMEM_ARB_LOCK_EN` defined:
  - p1_lock port exists.
  - LOCK1 state is present.
  - Port 0 is starved while the lock is held.
- Undefined:
  - No p1_lock port.
  - FSM is ARB only.
  - Pure round-robin.

## Structure
- Shared package `dmem_arb_pkg`:
  - state enum: ARB, LOCK1
  - port-index constants P0 = 0, P1 = 1
  - localparam for the word-alignment mask
- One natural sub-module, `rr_pick2`: combinational two-way round-robin selector taking the two requests and `last`, returning a one-hot grant.

## Test plan
- Reset, then p0 write addr 8 = 0xAAAABBBB alone:
  - p0_gnt = 1 same cycle, mem_we = 1.
  - A following p0 read of addr 8 → p0_rvalid next cycle, p0_rdata = 0xAAAABBBB.
- Both request every cycle (p0 reads addr 8, p1 reads addr 12 = 0xCCCCDDDD):
  - Grants 0,1,0,1.
  - Each rvalid returns the correct data one cycle later.
- p1 write addr 13 (misaligned):
  - Granted, mem_we = 0, misalign_err pulses next cycle.
  - Memory at addr 12 is unchanged.
- With DMEM_ARB_LOCK_EN: p1 granted with p1_lock = 1 for 4 cycles while p0 requests:
  - p0_gnt = 0 throughout.
  - When the lock drops, p0 is granted that cycle.
- Assert rst low in the cycle after a granted read:
  - rvalid stays 0 and state returns to ARB.
  - After release, p0 wins the first contention.
